// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared ISA constants and fetch state encoding
//
// Holds the instruction width, the NOP and HALT words, the jump-select
// encodings used by the decoder and fetch unit, and the fetch FSM states.
package isa_pkg;

  localparam int INSTR_W = 18;

  // Instructions are numbered [0:INSTR_W-1], so bit 0 is the MSB.
  // NOP has bits [0:1] = 11 and decodes to all-zero controls.
  localparam logic [0:INSTR_W-1] NOP  = 18'h30000;
  localparam logic [0:INSTR_W-1] HALT = 18'h3FFFF;

  // Jump-select field; flags are ordered {carry, zero, neg}.
  localparam logic [2:0] JSEL_NEVER  = 3'b000;
  localparam logic [2:0] JSEL_ALWAYS = 3'b001;
  localparam logic [2:0] JSEL_C      = 3'b010;
  localparam logic [2:0] JSEL_NC     = 3'b011;
  localparam logic [2:0] JSEL_Z      = 3'b100;
  localparam logic [2:0] JSEL_NZ     = 3'b101;
  localparam logic [2:0] JSEL_N      = 3'b110;
  localparam logic [2:0] JSEL_NN     = 3'b111;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/jump_cond.sv
// rtl/jump_cond.sv - jump condition evaluator
//
// Ports:
//   i_jSel   in  3  jump-select field
//   i_flags  in  3  {carry, zero, neg}
//   o_taken  out 1  condition selected by i_jSel is true
module jump_cond
  import isa_pkg::*;
(
  input  logic [2:0] i_jSel,
  input  logic [2:0] i_flags,
  output logic       o_taken
);

  logic carry, zero, neg;

  assign carry = i_flags[2];
  assign zero  = i_flags[1];
  assign neg   = i_flags[0];

  always_comb begin
    o_taken = 1'b0;
    case (i_jSel)
      JSEL_NEVER:  o_taken = 1'b0;
      JSEL_ALWAYS: o_taken = 1'b1;
      JSEL_C:      o_taken = carry;
      JSEL_NC:     o_taken = !carry;
      JSEL_Z:      o_taken = zero;
      JSEL_NZ:     o_taken = !zero;
      JSEL_N:      o_taken = neg;
      JSEL_NN:     o_taken = !neg;
      default:     o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch sequencer feeding the control unit
//
// Ports:
//   i_clk          in  1        clock, rising edge
//   i_rst          in  1        asynchronous active-high reset
//   o_imemAddr     out ADDR_W   program-memory read address (current PC)
//   i_imemData     in  [0:17]   read data for the previous cycle's address
//   i_stall        in  1        freeze all fetch state this cycle
//   i_jSel         in  3        jump condition of o_instruction (from decoder)
//   i_jOff         in  6        signed PC-relative offset (from decoder)
//   i_flags        in  3        {carry, zero, neg} from the datapath
//   o_instruction  out [0:17]   instruction presented to the decoder
//   o_instrValid   out 1        o_instruction is a real fetched word
//   o_instrPc      out ADDR_W   address of o_instruction
//   o_halted       out 1        fetch stopped on HALT
module instr_fetch
  import isa_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic [ADDR_W-1:0]  o_imemAddr,
  input  logic [0:INSTR_W-1] i_imemData,
  input  logic               i_stall,
  input  logic [2:0]         i_jSel,
  input  logic [5:0]         i_jOff,
  input  logic [2:0]         i_flags,
  output logic [0:INSTR_W-1] o_instruction,
  output logic               o_instrValid,
  output logic [ADDR_W-1:0]  o_instrPc,
  output logic               o_halted
);

  fetch_state_t       state, state_n;
  logic [ADDR_W-1:0]  pc, pc_n;
  logic [0:INSTR_W-1] instr, instr_n;
  logic               valid, valid_n;
  logic [ADDR_W-1:0]  ipc, ipc_n;
  logic               halted, halted_n;

  logic               cond_true;
  logic [ADDR_W-1:0]  target;

  jump_cond u_jump_cond (
    .i_jSel  (i_jSel),
    .i_flags (i_flags),
    .o_taken (cond_true)
  );

  // Sign-extend the 6-bit offset wide, add, then wrap to the PC width.
  // This also covers address widths narrower than the offset field.
  assign target = ADDR_W'(32'(ipc) + {{26{i_jOff[5]}}, i_jOff});

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    instr_n  = instr;
    valid_n  = valid;
    ipc_n    = ipc;
    halted_n = halted;
    if (!i_stall) begin
      case (state)
        FILL: begin
          // Memory output is stale or wrong-path here; start the new stream.
          pc_n    = pc + ADDR_W'(1);
          instr_n = NOP;
          valid_n = 1'b0;
          state_n = RUN;
        end
        RUN: begin
          // Only a real instruction may redirect; a bubble's decode is ignored.
          if (valid && cond_true) begin
            pc_n    = target;
            instr_n = NOP;
            valid_n = 1'b0;
            state_n = FILL;
          end else if (i_imemData == HALT) begin
            instr_n  = NOP;
            valid_n  = 1'b0;
            halted_n = 1'b1;
            state_n  = HALTED;
          end else begin
            instr_n = i_imemData;
            ipc_n   = pc - ADDR_W'(1);
            valid_n = 1'b1;
            pc_n    = pc + ADDR_W'(1);
          end
        end
        HALTED: begin
          // Sticky until reset.
        end
        default: begin
          state_n = FILL;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= FILL;
      pc     <= '0;
      instr  <= NOP;
      valid  <= 1'b0;
      ipc    <= '0;
      halted <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      instr  <= instr_n;
      valid  <= valid_n;
      ipc    <= ipc_n;
      halted <= halted_n;
    end
  end

  assign o_imemAddr    = pc;
  assign o_instruction = instr;
  assign o_instrValid  = valid;
  assign o_instrPc     = ipc;
  assign o_halted      = halted;

endmodule
